// File: rtl/byte_striping_pkg.sv
// Shared types and constants for the byte striping block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package byte_striping_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [7:0] lane_t;
    typedef lane_t [NUM_LANES-1:0] group_t;

    // K28.5 data value, used to fill lanes of a flushed partial group
    localparam lane_t DEFAULT_PAD_BYTE = 8'hBC;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Even parity per lane: bit i is the XOR of all bits of lane i
    function automatic logic [NUM_LANES-1:0] group_parity(input group_t g);
        logic [NUM_LANES-1:0] p;
        for (int i = 0; i < NUM_LANES; i++) begin
            p[i] = ^g[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/byte_striping_outreg.sv
// One-entry valid/ready holding register for a 4-lane group.
// Latency: 1 cycle from load_i to lanes_valid_o.
// Backpressure: group held stable while lanes_valid_o && !lanes_ready_i; caller loads only when empty or draining.
// Ports: clk/reset_L, load_i + group_i (new group), lanes_ready_i (consumer),
//        lanes_o/lanes_valid_o (held group), lane_parity_o when BYTE_STRIPING_PARITY_EN is defined.
module byte_striping_outreg
    import byte_striping_pkg::*;
(
    input  logic   clk,
    input  logic   reset_L,
    input  logic   load_i,
    input  group_t group_i,
    input  logic   lanes_ready_i,
    output group_t lanes_o,
    output logic   lanes_valid_o
`ifdef BYTE_STRIPING_PARITY_EN
    ,
    output logic [NUM_LANES-1:0] lane_parity_o
`endif
);

    out_state_t state_q;
    group_t     lanes_q;
`ifdef BYTE_STRIPING_PARITY_EN
    logic [NUM_LANES-1:0] parity_q;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= OUT_EMPTY;
            lanes_q  <= '0;
`ifdef BYTE_STRIPING_PARITY_EN
            parity_q <= '0;
`endif
        end else begin
            if (load_i) begin
                lanes_q  <= group_i;
`ifdef BYTE_STRIPING_PARITY_EN
                parity_q <= group_parity(group_i);
`endif
            end
            case (state_q)
                OUT_EMPTY: if (load_i) state_q <= OUT_FULL;
                // load while draining keeps FULL: back-to-back groups, no bubble
                OUT_FULL:  if (!load_i && lanes_ready_i) state_q <= OUT_EMPTY;
                default:   state_q <= OUT_EMPTY;
            endcase
        end
    end

    assign lanes_o       = lanes_q;
    assign lanes_valid_o = (state_q == OUT_FULL);
`ifdef BYTE_STRIPING_PARITY_EN
    assign lane_parity_o = parity_q;
`endif

endmodule

// File: rtl/byte_striping.sv
// Stripes a serial byte stream round-robin over four lanes, emitted as 4-byte groups.
// Latency: 1 cycle from the 4th accepted byte (or an effective flush) to lanes_valid.
// Backpressure: in_ready drops only for the slot-3 byte while the output group is stalled; flush waits likewise.
// Ports: in_data/in_valid/in_ready (byte input), flush (pad out partial group),
//        Lane_0..Lane_3/lanes_valid/lanes_ready (group output), ctr_3 (next slot index),
//        lane_parity (only with BYTE_STRIPING_PARITY_EN defined).
module byte_striping
    import byte_striping_pkg::*;
#(
    parameter lane_t PAD_BYTE = DEFAULT_PAD_BYTE,
    parameter int    LANE_W   = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [LANE_W-1:0] Lane_0,
    output logic [LANE_W-1:0] Lane_1,
    output logic [LANE_W-1:0] Lane_2,
    output logic [LANE_W-1:0] Lane_3,
    output logic              lanes_valid,
    input  logic              lanes_ready,
    output logic [1:0]        ctr_3
`ifdef BYTE_STRIPING_PARITY_EN
    ,
    output logic [NUM_LANES-1:0] lane_parity
`endif
);

    logic [1:0]  ctr_q, ctr_d;
    lane_t [2:0] collect_q, collect_d;   // slot 3 is never stored: it is always the live byte
    logic        can_load;
    logic        accept;
    logic        flush_go;
    logic        xfer;
    group_t      group;
    group_t      lanes;

    always_comb begin
        can_load = !lanes_valid || lanes_ready;
        in_ready = !((ctr_q == 2'd3) && !can_load);
        accept   = in_valid && in_ready;
        // flush with nothing collected is a no-op; otherwise it waits for the output register
        flush_go = flush && (ctr_q != 2'd0) && can_load;
        xfer     = (accept && (ctr_q == 2'd3)) || flush_go;

        // slots below ctr are collected, slot ctr takes the live byte, the rest are padded
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < ctr_q)                 group[i] = collect_q[i];
            else if (2'(i) == ctr_q && accept) group[i] = in_data;
            else                               group[i] = PAD_BYTE;
        end
        group[3] = (accept && (ctr_q == 2'd3)) ? in_data : PAD_BYTE;

        collect_d = collect_q;
        for (int i = 0; i < 3; i++) begin
            if (accept && (ctr_q == 2'(i))) collect_d[i] = in_data;
        end

        ctr_d = ctr_q;
        if (xfer)        ctr_d = 2'd0;
        else if (accept) ctr_d = ctr_q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ctr_q     <= 2'd0;
            collect_q <= '0;
        end else begin
            ctr_q     <= ctr_d;
            collect_q <= collect_d;
        end
    end

    byte_striping_outreg u_outreg (
        .clk           (clk),
        .reset_L       (reset_L),
        .load_i        (xfer),
        .group_i       (group),
        .lanes_ready_i (lanes_ready),
        .lanes_o       (lanes),
        .lanes_valid_o (lanes_valid)
`ifdef BYTE_STRIPING_PARITY_EN
        ,
        .lane_parity_o (lane_parity)
`endif
    );

    assign Lane_0 = lanes[0];
    assign Lane_1 = lanes[1];
    assign Lane_2 = lanes[2];
    assign Lane_3 = lanes[3];
    assign ctr_3  = ctr_q;

endmodule

// File: tb/tb_byte_striping.sv
// Scoreboard bench for byte_striping: expected groups queued as bytes are driven,
// popped and compared whenever the DUT hands a group over (lanes_valid && lanes_ready).
// Build with BYTE_STRIPING_PARITY_EN defined to also check lane_parity.
module tb_byte_striping;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] Lane_0, Lane_1, Lane_2, Lane_3;
    logic       lanes_valid;
    logic       lanes_ready;
    logic [1:0] ctr_3;
`ifdef BYTE_STRIPING_PARITY_EN
    logic [3:0] lane_parity;
`endif

    byte_striping dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .Lane_0      (Lane_0),
        .Lane_1      (Lane_1),
        .Lane_2      (Lane_2),
        .Lane_3      (Lane_3),
        .lanes_valid (lanes_valid),
        .lanes_ready (lanes_ready),
        .ctr_3       (ctr_3)
`ifdef BYTE_STRIPING_PARITY_EN
        ,
        .lane_parity (lane_parity)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [7:0] PAD = 8'hBC;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] exp_q[$];
    int          pop_cyc[$];
    logic [7:0]  slots[4];
    int          cnt = 0;
    logic        hold_vld = 1'b0;
    logic [31:0] hold_dat;
    logic [31:0] lanes_w;

    assign lanes_w = {Lane_3, Lane_2, Lane_1, Lane_0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] par4(input logic [31:0] g);
        return {^g[31:24], ^g[23:16], ^g[15:8], ^g[7:0]};
    endfunction

    task automatic push_group();
        exp_q.push_back({slots[3], slots[2], slots[1], slots[0]});
    endtask

    task automatic model_accept(input logic [7:0] b);
        slots[cnt] = b;
        cnt++;
        if (cnt == 4) begin
            push_group();
            cnt = 0;
        end
    endtask

    function automatic logic exp_rdy();
        return !(cnt == 3 && lanes_valid && !lanes_ready);
    endfunction

    // Group output monitor: scoreboard pop plus hold-stability check
    always @(negedge clk) begin
        if (!reset_L) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) chk("hold_stable", lanes_w, hold_dat);
            if (lanes_valid && lanes_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_grp", {31'b0, lanes_valid}, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("grp", lanes_w, e);
`ifdef BYTE_STRIPING_PARITY_EN
                    chk("parity", {28'b0, lane_parity}, {28'b0, par4(e)});
`endif
                    pop_cyc.push_back(cyc);
                end
            end
            hold_vld = lanes_valid && !lanes_ready;
            hold_dat = lanes_w;
        end
    end

    // Entered and left at posedge+1; one accepted byte per cycle when never stalled
    task automatic send(input logic [7:0] b);
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            logic r;
            @(negedge clk);
            r = exp_rdy();
            chk("in_ready", {31'b0, in_ready}, {31'b0, r});
            chk("ctr_3", {30'b0, ctr_3}, 32'(cnt));
            if (r) begin
                model_accept(b);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", {31'b0, ok}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_flush(input logic with_byte, input logic [7:0] b);
        logic done = 1'b0;
        flush    = 1'b1;
        in_valid = with_byte;
        in_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            logic r, can_load, acc;
            @(negedge clk);
            r        = exp_rdy();
            can_load = !lanes_valid || lanes_ready;
            acc      = in_valid && r;
            chk("flush_rdy", {31'b0, in_ready}, {31'b0, r});
            chk("flush_ctr", {30'b0, ctr_3}, 32'(cnt));
            if (cnt == 0) begin
                if (acc) model_accept(b);
                done = 1'b1;
            end else if (can_load) begin
                int k = cnt;
                if (acc) begin
                    slots[k] = b;
                    k++;
                end
                for (int j = k; j < 4; j++) slots[j] = PAD;
                push_group();
                cnt  = 0;
                done = 1'b1;
            end else if (acc) begin
                model_accept(b);
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        if (!done) chk("flush_timeout", {31'b0, done}, 32'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset_L     = 1'b0;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        flush       = 1'b0;
        lanes_ready = 1'b1;
        #12;
        chk("rst_vld",   {31'b0, lanes_valid}, 32'd0);
        chk("rst_ctr",   {30'b0, ctr_3}, 32'd0);
        chk("rst_lanes", lanes_w, 32'h0);
        chk("rst_rdy",   {31'b0, in_ready}, 32'd1);
`ifdef BYTE_STRIPING_PARITY_EN
        chk("rst_par",   {28'b0, lane_parity}, 32'd0);
`endif
        @(negedge clk); reset_L = 1'b1;
        @(posedge clk); #1;

        // basic group with one-cycle latency and single-cycle valid
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        @(negedge clk);
        chk("t1_vld",   {31'b0, lanes_valid}, 32'd1);
        chk("t1_lanes", lanes_w, 32'h04030201);
        chk("t1_ctr",   {30'b0, ctr_3}, 32'd0);
        @(negedge clk);
        chk("t1_vld_drop", {31'b0, lanes_valid}, 32'd0);
        @(posedge clk); #1;

        // continuous stream 00..0F: groups every 4 cycles, never blocked
        begin
            int start;
            pop_cyc.delete();
            start = cyc;
            for (int i = 0; i < 16; i++) send(8'(i));
            repeat (2) @(posedge clk); #1;
            chk("stream_groups", 32'(pop_cyc.size()), 32'd4);
            if (pop_cyc.size() == 4) begin
                chk("stream_first", 32'(pop_cyc[0] - start), 32'd4);
                for (int i = 0; i < 3; i++)
                    chk("stream_gap", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd4);
            end
        end

        // stall: slot-3 byte blocked while a group is held
        lanes_ready = 1'b0;
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        send(8'h21); send(8'h22); send(8'h23);
        in_valid = 1'b1;
        in_data  = 8'h24;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rdy",   {31'b0, in_ready}, 32'd0);
            chk("stall_lanes", lanes_w, 32'h14131211);
            @(posedge clk); #1;
        end
        lanes_ready = 1'b1;
        send(8'h24);
        @(negedge clk);
        chk("stall_next", lanes_w, 32'h24232221);
        @(posedge clk); #1;

        // flush after two bytes
        send(8'hAA); send(8'hBB);
        do_flush(1'b0, 8'h00);
        @(negedge clk);
        chk("fl_vld",   {31'b0, lanes_valid}, 32'd1);
        chk("fl_lanes", lanes_w, 32'hBCBCBBAA);
        chk("fl_ctr",   {30'b0, ctr_3}, 32'd0);
        @(posedge clk); #1;

        // flush with a same-cycle byte at slot 1, at slot 3, and at slot 0
        send(8'hC1); do_flush(1'b1, 8'hC2);
        send(8'hD1); send(8'hD2); send(8'hD3); do_flush(1'b1, 8'hD4);
        do_flush(1'b1, 8'hE1); send(8'hE2); send(8'hE3); send(8'hE4);
        do_flush(1'b0, 8'h00);

        // flush held pending behind a stalled group
        lanes_ready = 1'b0;
        send(8'h51); send(8'h52); send(8'h53); send(8'h54);
        send(8'h61);
        fork
            do_flush(1'b0, 8'h00);
            begin
                repeat (3) @(posedge clk);
                #2 lanes_ready = 1'b1;
            end
        join

        // parity pattern
        send(8'h01); send(8'h03); send(8'h07); send(8'hFF);
        @(negedge clk);
        chk("par_lanes", lanes_w, 32'hFF070301);
`ifdef BYTE_STRIPING_PARITY_EN
        chk("par_bits", {28'b0, lane_parity}, 32'b0101);
`endif
        @(posedge clk); #1;

        // asynchronous reset mid-group with a held group outstanding
        lanes_ready = 1'b0;
        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        send(8'h11); send(8'h22);
        in_valid = 1'b1;
        in_data  = 8'h55;
        #2 reset_L = 1'b0;
        #1;
        chk("arst_vld", {31'b0, lanes_valid}, 32'd0);
        chk("arst_ctr", {30'b0, ctr_3}, 32'd0);
        chk("arst_lanes", lanes_w, 32'h0);
        exp_q.delete();
        cnt         = 0;
        in_valid    = 1'b0;
        lanes_ready = 1'b1;
        @(negedge clk); #1 reset_L = 1'b1;
        @(posedge clk); #1;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        @(negedge clk);
        chk("post_rst", lanes_w, 32'h04030201);
        @(posedge clk); #1;

        // drain
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
